// File: rtl/postu_stream.sv
// Streaming tile transform: row pass on accept, column pass on emit (rf 4-row, de 6-row tiles).
// Define POSTU_SAT_EN to clamp results to OUT_BITS and raise the sticky sat_flag; otherwise results wrap.
module postu_stream #(
    parameter int A_BITS   = 12,
    parameter int OUT_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [5:0][A_BITS-1:0]   in_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0][OUT_BITS-1:0] out_row,
    output logic                     out_last,
    output logic                     sat_flag
);
    localparam int RW = A_BITS + 2;
    localparam int CW = A_BITS + 4;
    localparam int EW = CW + OUT_BITS;
`ifdef POSTU_SAT_EN
    localparam logic signed [EW-1:0] OMAX = {{(CW+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [EW-1:0] OMIN = {{(CW+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic                    mode_q, mode_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    sat_q, sat_d;
    logic [5:0][3:0][RW-1:0] buf_q, buf_d;

    logic                     accept, mode_eff, last_in, last_out, any_clamp;
    logic signed [RW-1:0]     x  [6];
    logic signed [RW-1:0]     rt [4];
    logic signed [CW-1:0]     r  [6];
    logic signed [CW-1:0]     y;
    logic signed [EW-1:0]     ye;
    logic [3:0][OUT_BITS-1:0] row_n;

    // First row of a tile uses the live in_mode; later rows use the latched one.
    assign accept   = in_valid & in_ready_q;
    assign mode_eff = (state_q == IDLE) ? in_mode : mode_q;
    assign last_in  = (cnt_q == (mode_eff ? 3'd3 : 3'd5));
    assign last_out = mode_q ? (idx_q == 2'd1) : (idx_q == 2'd3);

    always_comb begin
        for (int i = 0; i < 6; i++) x[i] = {{2{in_row[i][A_BITS-1]}}, in_row[i]};
        if (mode_eff) begin
            rt[0] = x[0] + x[1] + x[2];
            rt[1] = x[1] + x[3] - x[2];
            rt[2] = '0;
            rt[3] = '0;
        end else begin
            rt[0] = x[0] + x[1];
            rt[1] = x[3] + x[4];
            rt[2] = x[2] + x[1];
            rt[3] = x[4] + x[5];
        end
    end

    // Column pass for the output row selected by idx_q, then narrowing.
    always_comb begin
        any_clamp = 1'b0;
        row_n     = '0;
        for (int i = 0; i < 6; i++) r[i] = '0;
        y  = '0;
        ye = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 6; i++) r[i] = {{2{buf_q[i][j][RW-1]}}, buf_q[i][j]};
            y = '0;
            if (mode_q) begin
                if (j < 2) y = (idx_q[0] == 1'b0) ? r[0] + r[1] + r[2] : r[1] + r[3] - r[2];
            end else begin
                case (idx_q)
                    2'd0:    y = r[0] + r[1];
                    2'd1:    y = r[3] + r[4];
                    2'd2:    y = r[2] + r[1];
                    default: y = r[4] + r[5];
                endcase
            end
            ye = {{OUT_BITS{y[CW-1]}}, y};
`ifdef POSTU_SAT_EN
            if (ye > OMAX) begin
                row_n[j]  = OMAX[OUT_BITS-1:0];
                any_clamp = 1'b1;
            end else if (ye < OMIN) begin
                row_n[j]  = OMIN[OUT_BITS-1:0];
                any_clamp = 1'b1;
            end else begin
                row_n[j] = ye[OUT_BITS-1:0];
            end
`else
            row_n[j] = ye[OUT_BITS-1:0];
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        sat_d       = sat_q | (out_valid_q & any_clamp);
        buf_d       = buf_q;
        for (int rr = 0; rr < 6; rr++)
            if (accept && cnt_q == 3'(rr)) buf_d[rr] = {rt[3], rt[2], rt[1], rt[0]};
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    mode_d  = in_mode;
                    cnt_d   = 3'd1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (last_in) begin
                        cnt_d       = '0;
                        idx_d       = '0;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = EMIT;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    if (last_out) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            sat_q       <= sat_d;
        end
    end

    // Tile buffer needs no reset: it is only read after a full tile has been written.
    always_ff @(posedge clk) buf_q <= buf_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q & last_out;
    assign out_row   = out_valid_q ? row_n : '0;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_postu_stream.sv
// Bench for postu_stream: constant vectors, hand-written corner sequences and random tiles
// checked against an integer model of the two-pass transform.
module tb_postu_stream;
    localparam int AB = 12;
    localparam int OB = 12;

    logic                clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic                in_ready, out_valid, out_last, sat_flag;
    logic [5:0][AB-1:0]  in_row = '0;
    logic [3:0][OB-1:0]  out_row;

    int n_checks = 0, n_fail = 0;
    int tile_rows [6][6];
    bit tile_mode;
    int exp_rows [4][4];
    int exp_n;
    bit sat_exp = 1'b0;
    int got [4][4];

    typedef struct {
        bit mode;
        int row [6];
        int e0 [4];
        int el [4];
    } vec_t;
    vec_t vt [5];

    postu_stream #(.A_BITS(AB), .OUT_BITS(OB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic signed [31:0] act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // The same 1-D transform applies to rows and then to columns.
    function automatic void xform(input bit m, input int v[6], output int o[4]);
        if (m) begin
            o[0] = v[0] + v[1] + v[2]; o[1] = v[1] + v[3] - v[2]; o[2] = 0; o[3] = 0;
        end else begin
            o[0] = v[0] + v[1]; o[1] = v[3] + v[4]; o[2] = v[2] + v[1]; o[3] = v[4] + v[5];
        end
    endfunction

    function automatic int narrow(int v);
        int hi, lo, w;
        hi = (1 << (OB - 1)) - 1;
        lo = -(1 << (OB - 1));
        w  = 0;
`ifdef POSTU_SAT_EN
        if (v > hi) begin sat_exp = 1'b1; return hi; end
        if (v < lo) begin sat_exp = 1'b1; return lo; end
        return v;
`else
        w = v & ((1 << OB) - 1);
        if (w > hi) w -= (1 << OB);
        return w;
`endif
    endfunction

    function automatic void model();
        int rt [6][4];
        int v [6];
        int o [4];
        int nr;
        nr = tile_mode ? 4 : 6;
        for (int r = 0; r < 6; r++) begin
            v = tile_rows[r];
            xform(tile_mode, v, o);
            for (int j = 0; j < 4; j++) rt[r][j] = (r < nr) ? o[j] : 0;
        end
        exp_n = tile_mode ? 2 : 4;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 6; i++) v[i] = rt[i][j];
            xform(tile_mode, v, o);
            for (int k = 0; k < exp_n; k++) exp_rows[k][j] = narrow(o[k]);
        end
    endfunction

    function automatic void fill_random(bit big);
        for (int r = 0; r < 6; r++)
            for (int i = 0; i < 6; i++)
                tile_rows[r][i] = big ? int'($urandom_range(0, 4095)) - 2048
                                      : int'($urandom_range(0, 100)) - 50;
    endfunction

    task automatic send_row(input int r, input bit m);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_mode  = m;
        for (int i = 0; i < 6; i++) in_row[i] = AB'(tile_rows[r][i]);
        while (in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        if (in_ready !== 1'b1) chk("in_ready_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sat_flag", sat_flag, 0);
        for (int j = 0; j < 4; j++) chk($sformatf("rst_out_row_lane%0d", j), $signed(out_row[j]), 0);
        rst_n   = 1'b1;
        sat_exp = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
    endtask

    task automatic run_tile(input int stall_row, input int stall_len, input bit gaps, input bit flip);
        int nr, t;
        model();
        nr = tile_mode ? 4 : 6;
        for (int r = 0; r < nr; r++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_row(r, (r == 0) ? tile_mode : (flip ? !tile_mode : tile_mode));
        end
        chk("out_valid_latency", out_valid, 1);
        for (int k = 0; k < exp_n; k++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            if (out_valid !== 1'b1) chk("out_valid_timeout", out_valid, 1);
            if (k == stall_row) begin
                repeat (stall_len) begin
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_last", out_last, int'(k == exp_n - 1));
                    for (int j = 0; j < 4; j++)
                        chk($sformatf("stall_row%0d_lane%0d", k, j), $signed(out_row[j]), exp_rows[k][j]);
                    @(negedge clk);
                end
            end
            for (int j = 0; j < 4; j++) begin
                got[k][j] = $signed(out_row[j]);
                chk($sformatf("row%0d_lane%0d", k, j), $signed(out_row[j]), exp_rows[k][j]);
            end
            chk($sformatf("row%0d_out_last", k), out_last, int'(k == exp_n - 1));
            chk("emit_in_ready_low", in_ready, 0);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("out_valid_after_tile", out_valid, 0);
        chk("in_ready_after_tile", in_ready, 1);
        chk("sat_flag", sat_flag, int'(sat_exp));
    endtask

    initial begin
        vt[0].mode = 1'b1; vt[0].row = '{1, 2, 3, 4, 0, 0};
        vt[0].e0 = '{18, 9, 0, 0}; vt[0].el = '{6, 3, 0, 0};
        vt[1].mode = 1'b0; vt[1].row = '{1, 2, 3, 4, 5, 6};
        vt[1].e0 = '{6, 18, 10, 22}; vt[1].el = '{6, 18, 10, 22};
        vt[2].mode = 1'b1; vt[2].row = '{2047, 2047, 2047, 2047, 2047, 2047};
        vt[3].mode = 1'b0; vt[3].row = '{-2048, -2048, -2048, -2048, -2048, -2048};
        vt[4].mode = 1'b1; vt[4].row = '{-1, 5, -7, 3, 9, 9};
        vt[4].e0 = '{-9, 45, 0, 0}; vt[4].el = '{-3, 15, 0, 0};
`ifdef POSTU_SAT_EN
        vt[2].e0 = '{2047, 2047, 0, 0}; vt[2].el = '{2047, 2047, 0, 0};
        vt[3].e0 = '{-2048, -2048, -2048, -2048}; vt[3].el = '{-2048, -2048, -2048, -2048};
`else
        vt[2].e0 = '{2039, 2045, 0, 0}; vt[2].el = '{2045, 2047, 0, 0};
        vt[3].e0 = '{0, 0, 0, 0}; vt[3].el = '{0, 0, 0, 0};
`endif

        pulse_reset();

        for (int v = 0; v < 5; v++) begin
            tile_mode = vt[v].mode;
            for (int r = 0; r < 6; r++) tile_rows[r] = vt[v].row;
            run_tile(-1, 0, 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("vec%0d_first_lane%0d", v, j), got[0][j], vt[v].e0[j]);
                chk($sformatf("vec%0d_last_lane%0d", v, j), got[exp_n-1][j], vt[v].el[j]);
            end
        end

        // Backpressure: five stalled cycles on a middle de row.
        tile_mode = 1'b0; fill_random(1'b0);
        run_tile(1, 5, 1'b0, 1'b0);

        // in_mode toggled after the first row must not change the tile kind.
        tile_mode = 1'b1; fill_random(1'b0);
        run_tile(-1, 0, 1'b0, 1'b1);

        // Reset after two rows of an rf tile abandons it.
        tile_mode = 1'b1; fill_random(1'b1);
        send_row(0, 1'b1);
        send_row(1, 1'b1);
        pulse_reset();
        repeat (3) begin
            chk("no_valid_after_partial", out_valid, 0);
            @(negedge clk);
        end
        fill_random(1'b0);
        run_tile(-1, 0, 1'b0, 1'b0);

        // Reset while emitting.
        tile_mode = 1'b0; fill_random(1'b0);
        model();
        for (int r = 0; r < 6; r++) send_row(r, 1'b0);
        chk("emit_before_reset", out_valid, 1);
        pulse_reset();

        for (int n = 0; n < 20; n++) begin
            tile_mode = bit'($urandom_range(0, 1));
            fill_random(bit'($urandom_range(0, 1)));
            run_tile($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
